// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative RV32 M-extension unit for the EX stage.
// A radix-2 shift-add multiplier and a restoring divider share one adder.
// The unit holds the pipeline stall while it works, pulses done for one
// cycle with the result, and drops the operation on a pipeline flush.
// Handshake: start is accepted only in IDLE with flush low; stall covers the
// accepting cycle and every working cycle. done is a one-cycle valid pulse
// with result stable, and result holds until the next done.
// Optional build macro MDU_FAST_ZERO_EN: zero operands finish in one cycle.
`timescale 1ns/1ps
module mdu_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              a_sign_q, a_sign_d;
  logic              b_sign_q, b_sign_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] prod_q, prod_d;     // {hi, lo}: product, or {rem, quot}
  logic [XLEN-1:0]   result_q, result_d;

  logic              accept, special;
  logic              a_neg_in, b_neg_in, a_zero, b_zero, div_ovf;
  logic [XLEN-1:0]   a_abs, b_abs, special_res;
  logic [XLEN+1:0]   add_a, add_b, sum;
  logic              add_ci;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s, rem_s, fix_res;

  // Decode the incoming request: signs, magnitudes and one-cycle cases.
  always_comb begin
    accept   = (state_q == S_IDLE) && start && !flush;
    a_zero   = (op_a == '0);
    b_zero   = (op_b == '0);
    if (funct3[2]) begin
      a_neg_in = !funct3[0] && op_a[XLEN-1];
      b_neg_in = !funct3[0] && op_b[XLEN-1];
    end else begin
      a_neg_in = (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10) && op_a[XLEN-1];
      b_neg_in = (funct3[1:0] == 2'b01) && op_b[XLEN-1];
    end
    a_abs    = a_neg_in ? -op_a : op_a;
    b_abs    = b_neg_in ? -op_b : op_b;
    div_ovf  = funct3[2] && !funct3[0] && (op_a == MIN_NEG) && (op_b == '1);
    special  = funct3[2] && (b_zero || div_ovf);
`ifdef MDU_FAST_ZERO_EN
    special  = special || (!funct3[2] && (a_zero || b_zero)) ||
               (funct3[2] && a_zero && !b_zero);
`endif
    if (funct3[2] && b_zero) special_res = funct3[1] ? op_a : '1;
    else if (div_ovf)        special_res = funct3[1] ? '0 : MIN_NEG;
    else                     special_res = '0;
  end

  // Shared adder: add multiplicand to product high half, or trial-subtract
  // the divisor from the left-shifted remainder (carry-in completes ~b+1).
  always_comb begin
    if (funct3_q[2]) begin
      add_a  = {1'b0, prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
      add_b  = ~{2'b00, opnd_q};
      add_ci = 1'b1;
    end else begin
      add_a  = {2'b00, prod_q[2*XLEN-1:XLEN]};
      add_b  = prod_q[0] ? {2'b00, opnd_q} : '0;
      add_ci = 1'b0;
    end
  end
  assign sum = add_a + add_b + {{(XLEN+1){1'b0}}, add_ci};

  // Sign fix-up and output selection for the FIX cycle.
  always_comb begin
    prod_s = (a_sign_q ^ b_sign_q) ? -prod_q : prod_q;
    quot_s = (a_sign_q ^ b_sign_q) ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
    rem_s  = a_sign_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
    if (funct3_q[2])                fix_res = funct3_q[1] ? rem_s : quot_s;
    else if (funct3_q[1:0] == 2'b00) fix_res = prod_s[XLEN-1:0];
    else                             fix_res = prod_s[2*XLEN-1:XLEN];
  end

  // FSM next state and control outputs; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = special ? S_DONE : S_CALC;
      S_CALC:  if (cnt_q == '0) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
    busy      = (state_q != S_IDLE);
    stall     = (start && state_q == S_IDLE) || state_q == S_CALC || state_q == S_FIX;
    done      = (state_q == S_DONE) && !flush;
    result    = result_q;
    dbg_state = state_q;
  end

  // Datapath next state: capture on accept, iterate in CALC, write in FIX.
  always_comb begin
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    a_sign_d = a_sign_q;
    b_sign_d = b_sign_q;
    opnd_d   = opnd_q;
    prod_d   = prod_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: if (accept) begin
        funct3_d = funct3;
        a_sign_d = a_neg_in;
        b_sign_d = b_neg_in;
        cnt_d    = CNT_W'(XLEN-1);
        if (funct3[2]) begin
          prod_d = {{XLEN{1'b0}}, a_abs};
          opnd_d = b_abs;
        end else begin
          prod_d = {{XLEN{1'b0}}, b_abs};
          opnd_d = a_abs;
        end
        if (special) result_d = special_res;
      end
      S_CALC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (funct3_q[2])
          prod_d = {sum[XLEN+1] ? add_a[XLEN-1:0] : sum[XLEN-1:0],
                    prod_q[XLEN-2:0], ~sum[XLEN+1]};
        else
          prod_d = {sum[XLEN:0], prod_q[XLEN-1:1]};
      end
      S_FIX: if (!flush) result_d = fix_res;
      default: ;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      funct3_q <= '0;
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      opnd_q   <= '0;
      prod_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      a_sign_q <= a_sign_d;
      b_sign_q <= b_sign_d;
      opnd_q   <= opnd_d;
      prod_q   <= prod_d;
      result_q <= result_d;
    end
  end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide sequencer for the EX stage of the interrupt-capable RV32 pipeline.
- Runs an iterative radix-2 shift-add multiplier and a restoring divider, both on one shared internal adder.
- Drives the pipeline stall for the whole operation and hands the result to EX on a one-cycle done pulse.
- Aborts on an interrupt/exception flush.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request from EX; sampled only in IDLE.
- funct3  input  3  M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  XLEN  rs1 operand; captured on accepted start.
- op_b  input  XLEN  rs2 operand; captured on accepted start.
- flush  input  1  pipeline flush (interrupt/exception); aborts the operation.
- busy  output  1  high in any state other than IDLE.
- stall  output  1  freezes IF/ID/EX; = (start & IDLE) | CALC | FIX.
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  registered result; held until the next done.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, counter=0.
  - busy=0, stall=0, done=0, result=0.
  - Applies from any state, including mid-operation.
- States: IDLE, CALC, FIX, DONE.
- Cycle numbering: T0 is the cycle where start=1 in IDLE (accepted).
- IDLE:
  - On accepted start, latch op_a, op_b and funct3.
  - Latch sign flags: a signed for MULH/MULHSU/DIV/REM; b signed for MULH/DIV/REM.
  - Latch absolute values of the signed operands.
  - Load counter=XLEN-1.
  - Next state is CALC, unless a special case applies (below), in which case next state is DONE.
- CALC (T1..T_XLEN), one iteration per cycle:
  - Multiply: if multiplier LSB=1, add multiplicand into the upper half of a 2*XLEN product; then shift the product right 1.
  - Divide: shift {rem,quot} left 1; trial-subtract the divisor from rem; if non-negative, keep the difference and set quot LSB.
  - Counter decrements each cycle; at counter=0 go to FIX.
- FIX (T_XLEN+1):
  - Negate the product if a_sign^b_sign.
  - Negate the quotient if a_sign^b_sign.
  - Negate the remainder if a_sign.
  - Select the output half: MUL = low XLEN bits; MULH/MULHSU/MULHU = high XLEN bits.
  - Write result; next state DONE.
- DONE (T_XLEN+2):
  - done=1, stall=0, so EX captures result this cycle.
  - Next state IDLE.
  - A start in this cycle is ignored; back-to-back starts are accepted no earlier than T_XLEN+3.
- Nominal latency: done at T_XLEN+2 (T34 for XLEN=32); stall high T0..T33.
- Special cases (IDLE goes straight to DONE; result written at the T0 edge; done at T1; stall high T0 only):
  - DIV/DIVU with op_b=0 → result = all ones.
  - REM/REMU with op_b=0 → result = op_a.
  - DIV with op_a=0x80000000 and op_b=0xFFFFFFFF → result = 0x80000000.
  - REM with op_a=0x80000000 and op_b=0xFFFFFFFF → result = 0.
- flush:
  - Flush in CALC, FIX or DONE → IDLE on the next edge, result unchanged.
  - Flush suppresses done in the same cycle.
  - flush=1 together with start in IDLE → start is not accepted.
  - flush has priority over every transition except reset.
- start while busy is ignored; latched operands are not disturbed.
- Arithmetic is modulo 2^XLEN. Absolute value of 0x80000000 is taken unsigned as 2^31 (XLEN+1-bit intermediate).

Optional Feature:
- MDU_FAST_ZERO_EN defined:
  - Multiply ops with op_a=0 or op_b=0 take the special-case path: result=0, done at T1.
  - DIV/DIVU/REM/REMU with op_a=0 and op_b≠0 take the special-case path: result=0, done at T1.
- Undefined: these operands take the full XLEN+2-cycle path and produce the same values.

Test Plan:
- MUL op_a=7, op_b=6, start at T0 → stall T0..T33, done at T34 only, result=42; busy=0 at T35.
- MULH op_a=0xFFFFFFFF (-1), op_b=2 → result=0xFFFFFFFF. Same operands with MULHU → result=0x00000001.
- DIV op_a=-7 (0xFFFFFFF9), op_b=2 → result=0xFFFFFFFD (-3). REM with the same operands → result=0xFFFFFFFF (-1).
- DIVU op_b=0, op_a=0x1234 → done at T1, result=0xFFFFFFFF. REMU with the same operands → result=0x1234. DIV op_a=0x80000000, op_b=0xFFFFFFFF → done at T1, result=0x80000000.
- DIVU op_a=100, op_b=7:
  - flush at T10 → IDLE at T11, no done, result keeps its prior value.
  - A fresh start at T11 yields done at T45 with result=14.
  - rst_n=0 at T5 of another operation → all outputs 0 at the next edge.
- start pulsed again at T5 during a MUL, and start held high in the DONE cycle → both ignored. With MDU_FAST_ZERO_EN defined: MUL op_b=0 → done at T1, result=0.
